// File: rtl/multicycle_controller.sv
// Multicycle control FSM for a 16-bit CR16-style datapath.
// Instruction encoding (opcode / extension):
//   R-type opcode 0000: AND 0001, OR 0010, XOR 0011, LSH 0100, ADD 0101,
//                       SUB 1001, CMP 1011, MOV 1101
//   Immediates (opcode): ANDI 0001, ORI 0010, XORI 0011, ADDI 0101, SUBI 1001,
//                        CMPI 1011, MOVI 1101, LUI 1111
//   opcode 0100: LOAD 0000, STOR 0100, JAL 1000, JCOND 1100
// Anything else halts with a sticky illegal_instruction flag.
module multicycle_controller #(
  parameter int unsigned MEMORY_LATENCY = 1,
  parameter int unsigned ENABLE_JUMPS   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] instruction_operation,
  input  logic [3:0] instruction_operation_extra,
  input  logic       condition_met,
  output logic [1:0] alu_a_select,
  output logic [1:0] alu_b_select,
  output logic [2:0] alu_operation,
  output logic       instruction_write_enable,
  output logic       program_counter_write_enable,
  output logic       status_write_enable,
  output logic       register_write_enable,
  output logic       memory_write_enable,
  output logic       memory_read_enable,
  output logic       program_counter_select,
  output logic       address_select,
  output logic [1:0] register_write_select,
  output logic       illegal_instruction
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecAlu, StExecCmp, StMemLoad,
    StMemStore, StExecJcond, StExecJal, StWrite, StHalt
  } state_e;

  localparam logic [3:0] LatLast = 4'(MEMORY_LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic [3:0] ext_q, ext_d;
  logic       cond_q, cond_d;
  logic [1:0] wsel_q, wsel_d;
  logic       illegal_q, illegal_d;

  // R-type instructions select their ALU function via the extension field.
  function automatic logic [3:0] alu_key(input logic [3:0] op, input logic [3:0] ext);
    return (op == 4'b0000) ? ext : op;
  endfunction

  function automatic logic is_alu(input logic [3:0] op, input logic [3:0] ext);
    logic [3:0] key;
    key = alu_key(op, ext);
    if (op == 4'b0000) begin
      return key inside {4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1001, 4'b1101};
    end
    return key inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001, 4'b1101, 4'b1111};
  endfunction

  function automatic logic is_cmp(input logic [3:0] op, input logic [3:0] ext);
    return (op == 4'b1011) || ((op == 4'b0000) && (ext == 4'b1011));
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [3:0] key);
    case (key)
      4'b0101: return 3'd0;
      4'b1001, 4'b1011: return 3'd1;
      4'b0001: return 3'd2;
      4'b0010: return 3'd3;
      4'b0011: return 3'd4;
      4'b1101: return 3'd5;
      4'b0100: return 3'd6;
      4'b1111: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Arithmetic immediates are sign-extended, logical ones zero-extended.
  function automatic logic [1:0] a_sel_of(input logic [3:0] op);
    if (op == 4'b0000) return 2'd1;
    if (op inside {4'b0101, 4'b1001, 4'b1011}) return 2'd2;
    return 2'd3;
  endfunction

  // Next-state and Moore outputs from state, counter and latched decode fields.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    ext_d     = ext_q;
    cond_d    = cond_q;
    wsel_d    = wsel_q;
    illegal_d = illegal_q;

    alu_a_select                 = 2'd0;
    alu_b_select                 = 2'd0;
    alu_operation                = 3'd0;
    instruction_write_enable     = 1'b0;
    program_counter_write_enable = 1'b0;
    status_write_enable          = 1'b0;
    register_write_enable        = 1'b0;
    memory_write_enable          = 1'b0;
    memory_read_enable           = 1'b0;
    program_counter_select       = 1'b0;
    address_select               = 1'b0;
    register_write_select        = 2'd0;

    case (state_q)
      StFetch: begin
        memory_read_enable = 1'b1;
        alu_b_select       = 2'd1;
        if (cnt_q == 4'd0) begin
          instruction_write_enable     = 1'b1;
          program_counter_write_enable = 1'b1;
          cnt_d                        = LatLast;
          state_d                      = StDecode;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDecode: begin
        op_d   = instruction_operation;
        ext_d  = instruction_operation_extra;
        cond_d = condition_met;
        wsel_d = 2'd0;
        if (is_alu(instruction_operation, instruction_operation_extra)) begin
          state_d = StExecAlu;
        end else if (is_cmp(instruction_operation, instruction_operation_extra)) begin
          state_d = StExecCmp;
        end else if ((instruction_operation == 4'b0100) &&
                     (instruction_operation_extra == 4'b0000)) begin
          state_d = StMemLoad;
          wsel_d  = 2'd1;
        end else if ((instruction_operation == 4'b0100) &&
                     (instruction_operation_extra == 4'b0100)) begin
          state_d = StMemStore;
        end else if ((ENABLE_JUMPS != 0) && (instruction_operation == 4'b0100) &&
                     (instruction_operation_extra == 4'b1100)) begin
          state_d = StExecJcond;
        end else if ((ENABLE_JUMPS != 0) && (instruction_operation == 4'b0100) &&
                     (instruction_operation_extra == 4'b1000)) begin
          state_d = StExecJal;
        end else begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end
      end
      StExecAlu: begin
        alu_a_select        = a_sel_of(op_q);
        alu_operation       = alu_op_of(alu_key(op_q, ext_q));
        status_write_enable = alu_key(op_q, ext_q) inside {4'b0101, 4'b1001};
        state_d             = StWrite;
      end
      StExecCmp: begin
        alu_a_select        = a_sel_of(op_q);
        alu_operation       = 3'd1;
        status_write_enable = 1'b1;
        state_d             = StFetch;
      end
      StMemLoad: begin
        address_select        = 1'b1;
        memory_read_enable    = 1'b1;
        register_write_select = 2'd1;
        if (cnt_q == 4'd0) begin
          cnt_d   = LatLast;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StMemStore: begin
        address_select      = 1'b1;
        memory_write_enable = 1'b1;
        if (cnt_q == 4'd0) begin
          cnt_d   = LatLast;
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StExecJcond: begin
        program_counter_select       = cond_q;
        program_counter_write_enable = cond_q;
        state_d                      = StFetch;
      end
      StExecJal: begin
        register_write_enable        = 1'b1;
        register_write_select        = 2'd2;
        program_counter_select       = 1'b1;
        program_counter_write_enable = 1'b1;
        state_d                      = StFetch;
      end
      StWrite: begin
        register_write_enable = 1'b1;
        register_write_select = wsel_q;
        state_d               = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
        cnt_d   = LatLast;
      end
    endcase
  end

  assign illegal_instruction = illegal_q;

  // State register with synchronous active-low reset that aborts any access.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StFetch;
      cnt_q     <= LatLast;
      op_q      <= 4'd0;
      ext_q     <= 4'd0;
      cond_q    <= 1'b0;
      wsel_q    <= 2'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      ext_q     <= ext_d;
      cond_q    <= cond_d;
      wsel_q    <= wsel_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
